// File: rtl/runner_engine.sv
// runner_engine: game-state engine for the Dot Runner side-scroller.
// Keeps a COLS-column obstacle field that scrolls toward column 0 on every
// game tick, fed by an LFSR obstacle generator with a minimum gap, plus a
// runner with clamped jump physics, collision detection and a score.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   start      in   start/restart request (level)
//   stop       in   abort current run (level)
//   jump       in   jump key (level, rising edge detected internally)
//   obs_inject in   force a maximum-height obstacle as the next new column
//   field      out  packed field, column k at [(COLS-k)*HBITS-1 -: HBITS]
//   runner_h   out  runner height above ground
//   score      out  ticks survived, saturating
//   state      out  0 READY, 1 RUN, 2 OVER
//   tick       out  one-cycle pulse on each game-tick cycle
//   game_over  out  high while in OVER
module runner_engine #(
    parameter int unsigned COLS       = 160,
    parameter int unsigned HBITS      = 2,
    parameter int unsigned RH_BITS    = 5,
    parameter int unsigned RATE       = 3000000,
    parameter int unsigned JUMP_TICKS = 15,
    parameter int unsigned RUNNER_COL = 0,
    parameter int unsigned MIN_GAP    = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    jump,
    input  logic                    obs_inject,
    output logic [COLS*HBITS-1:0]   field,
    output logic [RH_BITS-1:0]      runner_h,
    output logic [15:0]             score,
    output logic [1:0]              state,
    output logic                    tick,
    output logic                    game_over
);

    localparam int unsigned FW     = COLS * HBITS;
    localparam int unsigned CNT_W  = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int unsigned GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int unsigned RISE_W = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;
    localparam int unsigned OBS_HI = (COLS - RUNNER_COL) * HBITS - 1;

    localparam logic [RH_BITS-1:0] MAX_H     = '1;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(RATE - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(MIN_GAP);
    localparam logic [RISE_W-1:0]  RISE_LOAD = RISE_W'(JUMP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_RUN   = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [FW-1:0]       field_q, field_d;
    logic [RH_BITS-1:0]  h_q, h_d;
    logic [15:0]         score_q, score_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [RISE_W-1:0]   rise_q, rise_d;
    logic                pend_q, jump_prev_q, tick_q, game_over_q;
    logic [HBITS-1:0]    new_col, obs;
    logic                is_tick, jump_rise, consumed, hit, clear;

    // Per-tick datapath: generator, field shift, runner physics, collision.
    always_comb begin
        cnt_d  = (cnt_q == '0) ? CNT_LOAD : cnt_q - CNT_W'(1);
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        new_col = '0;
        if (obs_inject) begin
            new_col = '1;
        end else if (gap_q >= GAP_MAX && lfsr_d[7:6] == 2'b00) begin
            new_col = lfsr_d[HBITS-1:0];
            if (new_col == '0) begin
                new_col = HBITS'(1);
            end
        end

        if (new_col != '0) begin
            gap_d = '0;
        end else begin
            gap_d = (gap_q >= GAP_MAX) ? GAP_MAX : gap_q + GAP_W'(1);
        end

        field_d = {field_q[FW-HBITS-1:0], new_col};

        // A pending jump only launches from the ground; otherwise it waits.
        consumed = 1'b0;
        h_d      = h_q;
        rise_d   = rise_q;
        if (pend_q && h_q == '0) begin
            h_d      = RH_BITS'(1);
            rise_d   = RISE_LOAD;
            consumed = 1'b1;
        end else if (rise_q != '0) begin
            h_d    = (h_q == MAX_H) ? MAX_H : h_q + RH_BITS'(1);
            rise_d = rise_q - RISE_W'(1);
        end else if (h_q != '0) begin
            h_d = h_q - RH_BITS'(1);
        end

        obs     = field_d[OBS_HI -: HBITS];
        hit     = (obs != '0) && (32'(h_d) < 32'(obs));
        score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
    end

    // Next state; 'clear' re-applies the READY register values.
    always_comb begin
        is_tick   = (state_q == ST_RUN) && (cnt_q == '0);
        jump_rise = jump & ~jump_prev_q;
        state_d   = state_q;
        clear     = 1'b0;
        case (state_q)
            ST_READY: begin
                clear = 1'b1;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_READY;
                    clear   = 1'b1;
                end else if (is_tick && hit) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d = ST_READY;
                    clear   = 1'b1;
                end
            end
            default: begin
                state_d = ST_READY;
                clear   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_READY;
            game_over_q <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            game_over_q <= (state_d == ST_OVER);
            jump_prev_q <= jump;
        end

        if (reset || clear) begin
            field_q <= '0;
            h_q     <= '0;
            score_q <= '0;
            lfsr_q  <= SEED;
            cnt_q   <= CNT_LOAD;
            gap_q   <= '0;
            rise_q  <= '0;
            pend_q  <= 1'b0;
            // Only a one-cycle tick period can tick on the first RUN cycle.
            tick_q  <= !reset && (state_q == ST_READY) && start && (CNT_LOAD == '0);
        end else if (state_q == ST_RUN) begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == '0) && !(is_tick && hit);
            if (is_tick) begin
                lfsr_q  <= lfsr_d;
                gap_q   <= gap_d;
                field_q <= field_d;
                h_q     <= h_d;
                rise_q  <= rise_d;
                pend_q  <= (pend_q & ~consumed) | jump_rise;
                if (!hit) score_q <= score_d;
            end else begin
                pend_q <= pend_q | jump_rise;
            end
        end else begin
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end
    end

    assign field     = field_q;
    assign runner_h  = h_q;
    assign score     = score_q;
    assign state     = state_q;
    assign tick      = tick_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_runner_engine.sv
// Bench for runner_engine: directed scenarios plus random play, with a
// behavioural game model feeding a scoreboard checked on every DUT tick.
module tb_runner_engine;

    localparam int COLS = 8, HBITS = 2, RH_BITS = 3, RATE = 4;
    localparam int JT = 3, MIN_GAP = 2, RCOL = 0;
    localparam int MAXH = (1 << RH_BITS) - 1;

    logic        clk = 1'b0;
    logic        reset, start, stop, jump, obs_inject;
    logic [15:0] field;
    logic [2:0]  runner_h;
    logic [15:0] score;
    logic [1:0]  state;
    logic        tick, game_over;

    always #5 clk = ~clk;

    runner_engine #(
        .COLS(COLS), .HBITS(HBITS), .RH_BITS(RH_BITS), .RATE(RATE),
        .JUMP_TICKS(JT), .RUNNER_COL(RCOL), .MIN_GAP(MIN_GAP), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .jump(jump),
        .obs_inject(obs_inject), .field(field), .runner_h(runner_h),
        .score(score), .state(state), .tick(tick), .game_over(game_over)
    );

    typedef struct {
        int          cyc;
        logic [15:0] fld;
        int          h;
        int          sc;
        int          st;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state: field as an array of column heights.
    int m_state, m_phase, m_h, m_rise, m_gap, m_score, m_lfsr;
    int m_col[COLS];
    bit m_pend, m_prevj, m_ticked;

    function automatic void m_clear();
        for (int k = 0; k < COLS; k++) m_col[k] = 0;
        m_h = 0; m_rise = 0; m_gap = 0; m_score = 0; m_phase = 0;
        m_pend = 0; m_lfsr = 'hACE1;
    endfunction

    function automatic logic [15:0] m_field();
        logic [15:0] f;
        f = '0;
        for (int k = 0; k < COLS; k++) f[(COLS-k)*HBITS-1 -: HBITS] = 2'(m_col[k]);
        return f;
    endfunction

    function automatic bit m_tick_now();
        return (m_state == 1) && (((m_phase + 1) % RATE) == 0);
    endfunction

    function automatic void m_game_tick(bit inj, bit jedge);
        int nc;
        bit consumed;
        consumed = 0;
        m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
        if (inj) nc = 3;
        else if (m_gap >= MIN_GAP && ((m_lfsr >> 6) & 3) == 0) nc = ((m_lfsr & 3) == 0) ? 1 : (m_lfsr & 3);
        else nc = 0;
        m_gap = (nc != 0) ? 0 : ((m_gap + 1 > MIN_GAP) ? MIN_GAP : m_gap + 1);
        for (int k = 0; k < COLS - 1; k++) m_col[k] = m_col[k+1];
        m_col[COLS-1] = nc;
        if (m_pend && m_h == 0) begin
            m_h = 1; m_rise = JT - 1; consumed = 1;
        end else if (m_rise > 0) begin
            m_h = (m_h + 1 > MAXH) ? MAXH : m_h + 1;
            m_rise--;
        end else if (m_h > 0) begin
            m_h--;
        end
        m_pend = (m_pend && !consumed) || jedge;
        if (m_col[RCOL] != 0 && m_h < m_col[RCOL]) m_state = 2;
        else if (m_score < 65535) m_score++;
    endfunction

    function automatic void model_step(bit r, bit st, bit sp, bit jp, bit inj);
        bit tk, je;
        tk = m_tick_now();
        je = jp && !m_prevj;
        m_prevj = r ? 1'b0 : jp;
        if (r) begin
            m_clear(); m_state = 0;
        end else begin
            case (m_state)
                0: begin m_clear(); if (st) m_state = 1; end
                1: begin
                    if (sp) begin m_clear(); m_state = 0; end
                    else begin
                        m_phase++;
                        if (tk) m_game_tick(inj, je);
                        else if (je) m_pend = 1;
                    end
                end
                default: begin
                    m_pend = 0;
                    if (st) begin m_clear(); m_state = 0; end
                end
            endcase
        end
        m_ticked = tk;
        if (tk) q.push_back('{cyc, m_field(), m_h, m_score, m_state});
    endfunction

    task automatic drive(input bit r, input bit st, input bit sp, input bit jp, input bit inj);
        reset = r; start = st; stop = sp; jump = jp; obs_inject = inj;
        model_step(r, st, sp, jp, inj);
        @(posedge clk); #1;
    endtask

    task automatic next_tick(input bit jp, input bit inj);
        int n;
        n = 0;
        do begin
            drive(0, 0, 0, jp, inj && m_tick_now());
            n++;
        end while (!m_ticked && n < 2 * RATE);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [39:0] got, exp;
        got = {field, runner_h, score, state, tick, game_over};
        exp = {m_field(), 3'(m_h), 16'(m_score), 2'(m_state), m_tick_now(), 1'(m_state == 2)};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: on every DUT tick, compare the post-tick state.
    initial begin
        exp_t e;
        int c;
        forever begin
            @(negedge clk);
            if (tick === 1'b1) begin
                c = cyc;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_tick: DUT ticked in cycle %0d, none expected", c);
                end else begin
                    e = q.pop_front();
                    @(posedge clk); #1;
                    checks++;
                    if (e.cyc != c || field !== e.fld || runner_h !== 3'(e.h) ||
                        score !== 16'(e.sc) || state !== 2'(e.st) || game_over !== 1'(e.st == 2)) begin
                        failures++;
                        $display("FAIL tick_update: cyc=%0d field=%h h=%0d score=%0d state=%0d, expected cyc=%0d field=%h h=%0d score=%0d state=%0d",
                                 c, field, runner_h, score, state, e.cyc, e.fld, e.h, e.sc, e.st);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit jl, r, st, sp, inj;
        reset = 1; start = 0; stop = 0; jump = 0; obs_inject = 0;
        m_prevj = 0; m_ticked = 0; m_state = 0; m_clear();
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_model("reset_model");
        chk("reset_state", 32'(state), 0);
        chk("reset_tick", 32'(tick), 0);

        // Jump physics with a second press while airborne.
        drive(0, 1, 0, 0, 0);
        chk("start_run", 32'(state), 1);
        drive(0, 0, 0, 1, 0); drive(0, 0, 0, 0, 0);
        next_tick(0, 0); chk("jump_h1", 32'(runner_h), 1); chk("score1", 32'(score), 1);
        next_tick(0, 0); chk("jump_h2", 32'(runner_h), 2); chk("score2", 32'(score), 2);
        drive(0, 0, 0, 1, 0); drive(0, 0, 0, 0, 0);
        next_tick(0, 0); chk("jump_h3", 32'(runner_h), 3); chk("score3", 32'(score), 3);
        next_tick(0, 0); chk("fall_h2", 32'(runner_h), 2);
        next_tick(0, 0); chk("fall_h1", 32'(runner_h), 1);
        next_tick(0, 0); chk("land_h0", 32'(runner_h), 0);
        next_tick(0, 0); chk("pending_fires", 32'(runner_h), 1);
        check_model("run_a_model");

        // Reset in the middle of a run.
        drive(1, 0, 0, 0, 0);
        chk("reset_mid", {state, field, runner_h, score, tick, game_over}, 0);

        // Injected obstacle against a grounded runner.
        drive(0, 1, 0, 0, 0);
        next_tick(0, 1); chk("inject_col", 32'(field[1:0]), 3);
        repeat (6) next_tick(0, 0);
        chk("pre_hit_score", 32'(score), 7);
        next_tick(0, 0);
        chk("hit_state", 32'(state), 2);
        chk("hit_game_over", 32'(game_over), 1);
        chk("hit_score", 32'(score), 7);
        drive(0, 0, 0, 1, 0);
        repeat (6) drive(0, 0, 0, 0, 0);
        chk("over_frozen", {state, runner_h, score, tick}, {2'd2, 3'd0, 16'd7, 1'b0});
        drive(0, 1, 0, 0, 0);
        chk("over_to_ready", {state, field, score}, 0);
        drive(0, 1, 0, 0, 0);
        chk("restart_run", {state, score}, {2'd1, 16'd0});

        // Injected obstacle cleared by a timed jump.
        next_tick(0, 1);
        repeat (4) next_tick(0, 0);
        drive(0, 0, 0, 1, 0); drive(0, 0, 0, 0, 0);
        next_tick(0, 0);
        next_tick(0, 0);
        next_tick(0, 0);
        chk("clear_col0", 32'(field[15:14]), 3);
        chk("clear_h", 32'(runner_h), 3);
        chk("clear_state", 32'(state), 1);
        chk("clear_score", 32'(score), 8);

        // stop wins over start while running.
        drive(0, 1, 1, 0, 0);
        chk("stop_prio", {state, field, runner_h, score, tick}, 0);

        // Random play against the model.
        jl = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(499) == 0);
            st  = (m_state != 1) ? ($urandom_range(3) == 0) : ($urandom_range(199) == 0);
            sp  = ($urandom_range(299) == 0);
            inj = ($urandom_range(11) == 0);
            if ($urandom_range(3) == 0) jl = ~jl;
            drive(r, st, sp, jl, inj);
            if (i % 25 == 0) check_model("rand_snapshot");
        end

        drive(0, 0, 1, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0);
        check_model("final_model");
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_ticks: %0d expected ticks never seen", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/runner_engine.md
Name: runner_engine

Overview:
- Parametrised game-state engine for the Dot Runner side-scroller. Replaces the fixed 2-bit-per-column obstacle shifter and single-height jump logic.
- Holds a COLS-column scrolling obstacle field fed by an LFSR generator, plus a runner with clamped jump physics.
- Adds collision detection, a game-over state and a score counter.
- Sits between the control keys and the VGA display scanner. The scanner reads field and runner_h.

Parameters:
- COLS, 160: number of field columns.
- HBITS, 2: bits per column obstacle height; 0 means no obstacle.
- RH_BITS, 5: runner height width; MAX_H = 2^RH_BITS-1.
- RATE, 3000000: clk cycles per game tick.
- JUMP_TICKS, 15: rising ticks per jump, including the launch tick.
- RUNNER_COL, 0: column index checked for collision.
- MIN_GAP, 4: minimum empty columns between generated obstacles.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: start/restart request, level.
- stop, in, 1: abort run, level.
- jump, in, 1: jump key, level; edge-detected internally.
- obs_inject, in, 1: forces a maximum-height obstacle as the next generated column.
- field, out, COLS*HBITS: packed obstacle field. Column k is bits [(COLS-k)*HBITS-1 -: HBITS]; column 0 is leftmost.
- runner_h, out, RH_BITS: runner height above ground.
- score, out, 16: ticks survived, saturating.
- state, out, 2: 0 READY, 1 RUN, 2 OVER.
- tick, out, 1: one-cycle pulse on each game tick.
- game_over, out, 1: equals (state==OVER).

Behaviour:
Reset and READY state:
- reset (any state, mid-run included) goes to READY.
- In READY: field=0, runner_h=0, score=0, tick=0, lfsr=SEED, tick counter=RATE-1, gap_cnt=0, rise_cnt=0, jump_pending=0.
- The READY register values are re-applied every cycle while in READY.

State transitions (registered):
- READY: start -> RUN.
- RUN: stop -> READY. stop has priority over collision and over start.
- RUN: collision on a tick -> OVER.
- OVER: start -> READY. The next start then enters RUN.
- Latency: start at edge N gives state=RUN after edge N; the first tick occurs RATE cycles later.

Tick generation (RUN only):
- The counter decrements every cycle.
- At 0 it reloads RATE-1 and asserts tick for that cycle.
- All game updates occur on the tick cycle.

Jump input:
- Rising edge of jump, via a registered previous value, sets jump_pending in RUN.
- Pending is cleared when consumed on a tick, and cleared in READY/OVER.

Generator (each tick):
- The LFSR advances: 16-bit Galois, taps 16'hB400.
- If obs_inject is high on the tick cycle: new_col = all ones.
- Else if gap_cnt>=MIN_GAP and lfsr[7:6]==0: new_col = lfsr[HBITS-1:0], forced to a minimum of 1.
- Otherwise new_col = 0.
- gap_cnt resets to 0 on a nonzero column, else increments, saturating at MIN_GAP.

Field (each tick):
- field <= {field[COLS*HBITS-HBITS-1:0], new_col}: shift toward column 0; the new column enters at COLS-1.

Runner (each tick, in priority order):
1. If jump_pending and runner_h==0: runner_h=1, rise_cnt=JUMP_TICKS-1.
2. Else if rise_cnt>0: runner_h=min(runner_h+1, MAX_H), rise_cnt-1.
3. Else if runner_h>0: runner_h-1.
- A jump while airborne stays pending and fires only on landing, provided it is still pending.
- runner_h never wraps in either direction.

Collision:
- Evaluated on the post-shift column RUNNER_COL height obs and the post-update runner_h.
- hit = (obs!=0) && (runner_h < obs).
- On hit: state->OVER and score is not incremented.
- Otherwise score = score+1, saturating at 16'hFFFF.

OVER state:
- field, runner_h and score are frozen; tick=0; jump is ignored.

Test Plan (COLS=8, HBITS=2, RH_BITS=3, RATE=4, JUMP_TICKS=3, MIN_GAP=2, RUNNER_COL=0):
- Reset assertion mid-run -> next cycle state=0, field=0, runner_h=0, score=0, tick=0.
- start pulse -> state=1 next cycle; tick pulses every 4 cycles; score reads 1,2,3 after ticks 1-3; runner_h stays 0 with no jump.
- jump pulse while grounded -> runner_h over successive ticks reads 1,2,3,2,1,0. A second jump pulse at the height-2 rising tick must not raise the peak above 3.
- obs_inject on tick T with runner grounded -> field[1:0]=2'b11 after T. The column reaches column 0 at tick T+7, where state=2, game_over=1 and score is frozen (not incremented on T+7).
- Same injection with a jump timed so runner_h>=3 at tick T+7 -> no hit; state stays 1 and score increments.
- stop asserted together with start in RUN -> state=0, all cleared. In OVER, start -> READY; a further start -> RUN with score=0.
